// File: rtl/axi_req_arbiter.sv
// ============================================================================
// Module      : axi_req_arbiter
// Description : Two-requester round-robin arbiter in front of an AXI-lite
//               master. Each requester posts a single-cycle request that is
//               held until the downstream transaction completes and the
//               requester receives its one-cycle ack.
//               Optional feature macro: ARB_TIMEOUT_EN (WAIT-state timeout
//               that forces an error completion after TIMEOUT_CYCLES).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        aclk,
  input  logic        areset_n,
  // requester 0 (LSU)
  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_busy,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  // requester 1 (auxiliary master)
  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_busy,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  // downstream AXI-lite master
  output logic        start_write,
  output logic        start_read,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic        psel,
  input  logic        done,
  input  logic [31:0] rdata,
  input  logic        slverr,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_pending;
  logic        r_hold_we    [2];
  logic [31:0] r_hold_addr  [2];
  logic [31:0] r_hold_wdata [2];
  logic [3:0]  r_hold_wstrb [2];

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_grant;
  logic        r_last;        // 1 = m1 was served last
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [1:0]  w_valid;
  logic        w_req_we    [2];
  logic [31:0] w_req_addr  [2];
  logic [31:0] w_req_wdata [2];
  logic [3:0]  w_req_wstrb [2];
  logic        w_pick;        // winning requester index
  logic        w_load;
  logic        w_capture;
  logic        w_timeout;
  logic        w_release;
  logic        w_resp;

  assign w_valid        = {m1_valid, m0_valid};
  assign w_req_we[0]    = m0_we;
  assign w_req_we[1]    = m1_we;
  assign w_req_addr[0]  = m0_addr;
  assign w_req_addr[1]  = m1_addr;
  assign w_req_wdata[0] = m0_wdata;
  assign w_req_wdata[1] = m1_wdata;
  assign w_req_wstrb[0] = m0_wstrb;
  assign w_req_wstrb[1] = m1_wstrb;

  // With both pending the requester not served last wins; else the lone one.
  assign w_pick = (r_pending == 2'b11) ? ~r_last : r_pending[1];

`ifdef ARB_TIMEOUT_EN
  localparam int c_TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TCNT_W-1:0] r_tcnt;
  logic                w_tcnt_hit;

  assign w_tcnt_hit = (r_tcnt == c_TCNT_W'(TIMEOUT_CYCLES));

  // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)               r_tcnt <= '0;
    else if (r_state == S_WAIT)  r_tcnt <= r_tcnt + 1'b1;
    else                         r_tcnt <= '0;
  end
`else
  // No timeout hardware; the parameter is still referenced so it remains part
  // of the elaborated interface of this build.
  if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
  end
`endif

  // State register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_tcnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
`endif
      end
      S_RESP: begin
        w_release   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accept a request only when its slot is free; clear the slot on release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_pending <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        r_hold_we[n]    <= 1'b0;
        r_hold_addr[n]  <= '0;
        r_hold_wdata[n] <= '0;
        r_hold_wstrb[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_release && r_grant[n]) begin
          r_pending[n] <= 1'b0;
        end else if (w_valid[n] && !r_pending[n]) begin
          r_pending[n]    <= 1'b1;
          r_hold_we[n]    <= w_req_we[n];
          r_hold_addr[n]  <= w_req_addr[n];
          r_hold_wdata[n] <= w_req_wdata[n];
          r_hold_wstrb[n] <= w_req_wstrb[n];
        end
      end
    end
  end

  // Downstream fields and owner: loaded on grant, held through WAIT/RESP.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_grant <= 2'b00;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wstrb <= '0;
      r_last  <= 1'b1;
    end else if (w_load) begin
      r_grant <= w_pick ? 2'b10 : 2'b01;
      r_we    <= r_hold_we[w_pick];
      r_addr  <= r_hold_addr[w_pick];
      r_data  <= r_hold_wdata[w_pick];
      r_wstrb <= r_hold_wstrb[w_pick];
    end else if (w_release) begin
      r_grant <= 2'b00;
      r_last  <= r_grant[1];
    end
  end

  // Response capture; writes return zero data, a timeout returns an error.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_rdata <= r_we ? 32'h0 : rdata;
      r_rsp_err   <= slverr;
    end else if (w_timeout) begin
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b1;
    end
  end

  assign w_resp      = (r_state == S_RESP);
  assign start_write = (r_state == S_ISSUE) &  r_we;
  assign start_read  = (r_state == S_ISSUE) & ~r_we;
  assign psel        = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign addr        = r_addr;
  assign data        = r_data;
  assign wstrb       = r_wstrb;
  assign grant       = r_grant;

  assign m0_busy  = r_pending[0];
  assign m1_busy  = r_pending[1];
  assign m0_ack   = w_resp & r_grant[0];
  assign m1_ack   = w_resp & r_grant[1];
  assign m0_rdata = m0_ack ? r_rsp_rdata : 32'h0;
  assign m1_rdata = m1_ack ? r_rsp_rdata : 32'h0;
  assign m0_err   = m0_ack & r_rsp_err;
  assign m1_err   = m1_ack & r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_req_arbiter.sv
// ============================================================================
// Module      : tb_axi_req_arbiter
// Description : Directed self-checking bench for axi_req_arbiter.
//               Timeout scenario is built only with ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_req_arbiter;

  logic        aclk;
  logic        areset_n;
  logic        m0_valid, m0_we, m0_busy, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_we, m1_busy, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        start_write, start_read, psel, done, slverr;
  logic [31:0] addr, data, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  axi_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_busy(m0_busy), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_busy(m1_busy), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .start_write(start_write), .start_read(start_read), .addr(addr), .data(data),
    .wstrb(wstrb), .psel(psel), .done(done), .rdata(rdata), .slverr(slverr),
    .grant(grant)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Wait for the start pulse, complete the transaction and check the ack.
  task automatic expect_txn(input string tag, input logic [1:0] g, input logic we,
                            input logic [31:0] a, input logic [31:0] rd, input logic err);
    int n = 0;
    while (!(start_write || start_read) && n < 20) begin
      step();
      n++;
    end
    check({tag, "_start"}, 32'(start_write | start_read), 32'd1);
    check({tag, "_kind"},  32'(start_write), 32'(we));
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_addr"},  addr, a);
    step();
    step();
    check({tag, "_wait_grant"}, 32'(grant), 32'(g));
    done = 1'b1; rdata = rd; slverr = err;
    step();
    done = 1'b0; rdata = 32'h0; slverr = 1'b0;
    check({tag, "_ack"},   32'({m1_ack, m0_ack}), 32'(g));
    check({tag, "_rdata"}, g[1] ? m1_rdata : m0_rdata, we ? 32'h0 : rd);
    check({tag, "_err"},   32'(g[1] ? m1_err : m0_err), 32'(err));
    check({tag, "_resp_grant"}, 32'(grant), 32'(g));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n = 1'b0;
    m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    done = 0; rdata = 0; slverr = 0;
    repeat (2) step();

    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_psel",  32'(psel), 32'd0);
    check("rst_busy",  32'({m1_busy, m0_busy}), 32'd0);
    check("rst_addr",  addr, 32'h0);
    areset_n = 1'b1;
    step();

    // m0 write: start at t+2, ack one cycle after done
    m0_valid = 1; m0_we = 1; m0_addr = 32'h1000_0010; m0_wdata = 32'hA5; m0_wstrb = 4'hF;
    step();
    m0_valid = 0;
    check("w_busy",  32'(m0_busy), 32'd1);
    check("w_early", 32'(start_write), 32'd0);
    step();
    check("w_start", 32'(start_write), 32'd1);
    check("w_psel",  32'(psel), 32'd1);
    check("w_grant", 32'(grant), 32'd1);
    check("w_addr",  addr, 32'h1000_0010);
    check("w_data",  data, 32'h0000_00A5);
    check("w_wstrb", 32'(wstrb), 32'hF);
    step();
    check("w_start_once", 32'(start_write), 32'd0);
    check("w_wait_psel",  32'(psel), 32'd1);
    step();
    step();
    done = 1; rdata = 32'hDEAD_BEEF; slverr = 0;
    step();
    done = 0; rdata = 0;
    check("w_ack",   32'(m0_ack), 32'd1);
    check("w_err",   32'(m0_err), 32'd0);
    check("w_rdata", m0_rdata, 32'h0);
    check("w_resp_psel", 32'(psel), 32'd0);
    step();
    check("w_ack_pulse", 32'(m0_ack), 32'd0);
    check("w_idle_grant", 32'(grant), 32'd0);
    check("w_idle_busy", 32'(m0_busy), 32'd0);

    // done while idle is ignored
    done = 1; rdata = 32'h1234_5678;
    step();
    done = 0; rdata = 0;
    check("idle_done_ack", 32'({m1_ack, m0_ack}), 32'd0);
    check("idle_done_psel", 32'(psel), 32'd0);

    // m1 read
    m1_valid = 1; m1_we = 0; m1_addr = 32'h2000_0004;
    step();
    m1_valid = 0;
    expect_txn("r1", 2'b10, 1'b0, 32'h2000_0004, 32'h0000_0041, 1'b0);
    step();

    // Simultaneous requests twice: m0, m1, m0, m1
    m0_valid = 1; m0_we = 0; m0_addr = 32'h0000_0100;
    m1_valid = 1; m1_we = 0; m1_addr = 32'h0000_0200;
    step();
    m0_valid = 0; m1_valid = 0;
    expect_txn("rr_a", 2'b01, 1'b0, 32'h0000_0100, 32'h0000_0011, 1'b0);
    expect_txn("rr_b", 2'b10, 1'b0, 32'h0000_0200, 32'h0000_0022, 1'b1);
    // request during own RESP is ignored
    m1_valid = 1; m1_addr = 32'h0000_0BAD;
    step();
    m1_valid = 0;
    check("resp_req_drop", 32'(m1_busy), 32'd0);
    m0_valid = 1; m0_addr = 32'h0000_0300;
    m1_valid = 1; m1_addr = 32'h0000_0400;
    step();
    m0_valid = 0; m1_valid = 0;
    expect_txn("rr_c", 2'b01, 1'b0, 32'h0000_0300, 32'h0000_0033, 1'b0);
    expect_txn("rr_d", 2'b10, 1'b0, 32'h0000_0400, 32'h0000_0044, 1'b0);
    step();

    // Request while busy is dropped
    m0_valid = 1; m0_we = 0; m0_addr = 32'h3000_0000;
    step();
    m0_addr = 32'h3000_00FF;
    step();
    m0_valid = 0;
    expect_txn("drop", 2'b01, 1'b0, 32'h3000_0000, 32'h0000_0055, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drop_no_start", 32'(start_write | start_read | m0_busy), 32'd0);
    end

    // Reset during WAIT, then a stray done
    m0_valid = 1; m0_we = 1; m0_addr = 32'h4000_0000; m0_wdata = 32'h77; m0_wstrb = 4'h3;
    step();
    m0_valid = 0;
    step();
    step();
    check("rst_mid_psel_before", 32'(psel), 32'd1);
    areset_n = 1'b0;
    #1;
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_psel",  32'(psel), 32'd0);
    check("rst_mid_addr",  addr, 32'h0);
    check("rst_mid_wstrb", 32'(wstrb), 32'h0);
    step();
    areset_n = 1'b1;
    step();
    done = 1; rdata = 32'hCAFE_0000;
    step();
    done = 0; rdata = 0;
    check("rst_mid_ack",  32'({m1_ack, m0_ack}), 32'd0);
    check("rst_mid_busy", 32'({m1_busy, m0_busy}), 32'd0);
    check("rst_mid_start", 32'(start_write | start_read), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Timeout: ack 9 cycles after WAIT entry with error and zero data
    begin
      int n = 0;
      m1_valid = 1; m1_we = 0; m1_addr = 32'h5000_0000;
      step();
      m1_valid = 0;
      step();
      check("to_start", 32'(start_read), 32'd1);
      step();
      while (!m1_ack && n < 30) begin
        step();
        n++;
      end
      check("to_latency", 32'(n), 32'd9);
      check("to_err",   32'(m1_err), 32'd1);
      check("to_rdata", m1_rdata, 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
